// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl : load/store sequencer placed directly in front of the data RAM.
//
// Takes one RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) at a time over a
// valid/ready handshake. It maps the request onto the RAM's native primitives
// (word read, byte-unsigned read, word write, byte write), sign/zero-extends
// load data, checks alignment, and returns one registered response.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake from the execute stage
//   req_is_store      1 = store, 0 = load
//   req_funct3        RV32I load/store funct3
//   req_addr          byte address
//   req_wdata         store data (rs2)
//   rsp_valid         one-cycle response strobe
//   rsp_rdata         extended load result (0 for stores and faults)
//   rsp_fault         request faulted; there is no memory side effect
//   rsp_cause         01 misaligned, 10 unsupported funct3, 00 none
//   mem_*             RAM address/data/strobes/funct3; mem_read_data is
//                     combinational read data from the RAM
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter bit MISALIGN_CHECK = 1'b1,
    parameter bit EN_HALF        = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_cause,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_w_we,
    output logic        mem_b_we,
    output logic        mem_re,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_BYTE2  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] RAM_WORD_RD = 3'b010;
    localparam logic [2:0] RAM_BYTE_RD = 3'b100;

    logic [1:0]  state_q, state_d;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [1:0]  cause_q;

    logic        fire;
    logic        dec_half, dec_word;
    logic        dec_unsup, dec_misal;
    logic [1:0]  dec_cause;
    logic [31:0] dec_addr;

    // Extend the addressed byte/halfword of a RAM read according to funct3.
    // funct3[2] set means the unsigned variant (LBU/LHU).
    function automatic logic [31:0] ext_load(input logic [2:0]  f3,
                                             input logic [31:0] word,
                                             input logic        hi_half);
        logic [15:0] h;
        logic [7:0]  b;
        h = hi_half ? word[31:16] : word[15:0];
        b = word[7:0];
        case (f3[1:0])
            2'b00:   ext_load = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   ext_load = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: ext_load = word;
        endcase
    endfunction

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign fire      = req_valid && req_ready;

    // Request decode, evaluated on the live request inputs at accept.
    always_comb begin
        dec_half = (req_funct3[1:0] == 2'b01);
        dec_word = (req_funct3[1:0] == 2'b10);
        if (req_is_store) begin
            dec_unsup = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            dec_unsup = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        if (dec_half && !EN_HALF) begin
            dec_unsup = 1'b1;
        end
        dec_misal = MISALIGN_CHECK &&
                    ((dec_half && req_addr[0]) ||
                     (dec_word && (req_addr[1:0] != 2'b00)));
        // Unsupported outranks misaligned.
        dec_cause = dec_unsup ? 2'b10 : (dec_misal ? 2'b01 : 2'b00);
        // Forced alignment; a no-op for accepted requests when checking is on.
        dec_addr  = req_addr;
        if (dec_half) begin
            dec_addr[0] = 1'b0;
        end
        if (dec_word) begin
            dec_addr[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d = (dec_cause != 2'b00) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: state_d = (st_q && (f3_q[1:0] == 2'b01)) ? S_BYTE2 : S_RESP;
            S_BYTE2:  state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // RAM drive: everything is zero outside ACCESS/BYTE2 and while in reset,
    // so no write strobe can reach the RAM on an edge with rst high.
    always_comb begin
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_w_we       = 1'b0;
        mem_b_we       = 1'b0;
        mem_re         = 1'b0;
        mem_funct3     = 3'd0;
        if (!rst) begin
            if (state_q == S_ACCESS) begin
                if (!st_q) begin
                    mem_re = 1'b1;
                    if (f3_q[1:0] == 2'b00) begin
                        mem_funct3  = RAM_BYTE_RD;
                        mem_address = addr_q;
                    end else begin
                        mem_funct3  = RAM_WORD_RD;
                        mem_address = {addr_q[31:2], 2'b00};
                    end
                end else begin
                    mem_address = addr_q;
                    if (f3_q[1:0] == 2'b10) begin
                        mem_w_we       = 1'b1;
                        mem_write_data = wdata_q;
                    end else begin
                        mem_b_we       = 1'b1;
                        mem_write_data = {4{wdata_q[7:0]}};
                    end
                end
            end else if (state_q == S_BYTE2) begin
                // Upper byte of SH; address wraps modulo 2^32.
                mem_b_we       = 1'b1;
                mem_address    = addr_q + 32'd1;
                mem_write_data = {4{wdata_q[15:8]}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (fire) begin
                rdata_q <= 32'd0;
                fault_q <= (dec_cause != 2'b00);
                cause_q <= dec_cause;
            end else if ((state_q == S_ACCESS) && !st_q) begin
                rdata_q <= ext_load(f3_q, mem_read_data, addr_q[1]);
            end
        end
    end

    // Request fields are plain data: loaded on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (fire) begin
            st_q    <= req_is_store;
            f3_q    <= req_funct3;
            addr_q  <= dec_addr;
            wdata_q <= req_wdata;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
    assign rsp_cause = cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_w_we;
    logic        mem_b_we;
    logic        mem_re;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;

    int n_cmp = 0;
    int n_err = 0;

    // Environment RAM (4 KiB, byte array) and reference architectural memory.
    logic [7:0] ram [0:4095] = '{default: 8'h00};
    logic [7:0] mm  [0:4095];
    int nw_cnt = 0;
    int nb_cnt = 0;

    // Per-request snapshots of the RAM interface for cycles 1..3 after accept.
    logic [31:0] obs_addr  [1:3];
    logic [31:0] obs_wdata [1:3];
    logic [2:0]  obs_f3    [1:3];
    logic        obs_re    [1:3];
    logic        obs_bwe   [1:3];
    logic        obs_wwe   [1:3];

    lsu_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .rsp_cause      (rsp_cause),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_w_we       (mem_w_we),
        .mem_b_we       (mem_b_we),
        .mem_re         (mem_re),
        .mem_funct3     (mem_funct3),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // RAM read: funct3 100 = byte unsigned at address, otherwise aligned word.
    always_comb begin
        logic [11:0] wa;
        wa = {mem_address[11:2], 2'b00};
        mem_read_data = 32'd0;
        if (mem_funct3 == 3'b100) begin
            mem_read_data = {24'd0, ram[mem_address[11:0]]};
        end else begin
            mem_read_data = {ram[wa + 12'd3], ram[wa + 12'd2], ram[wa + 12'd1], ram[wa]};
        end
    end

    always @(posedge clk) begin
        if (mem_w_we) begin
            for (int k = 0; k < 4; k++) begin
                ram[{mem_address[11:2], 2'b00} + 12'(k)] <= mem_write_data[8*k +: 8];
            end
            nw_cnt <= nw_cnt + 1;
        end
        if (mem_b_we) begin
            ram[mem_address[11:0]] <= mem_write_data[7:0];
            nb_cnt <= nb_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the RV32I load/store rules on a byte array.
    function automatic void model_exec(input bit st, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic flt, output logic [1:0] cs,
                                       output logic [31:0] rd, output int lat,
                                       output int nw, output int nb);
        bit unsup, mis;
        int sz, v;
        logic [11:0] i;
        sz    = int'(f3[1:0]);
        unsup = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis   = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
        flt   = unsup || mis;
        cs    = unsup ? 2'b10 : (mis ? 2'b01 : 2'b00);
        rd    = 32'd0;
        nw    = 0;
        nb    = 0;
        lat   = 2;
        i     = a[11:0];
        if (flt) begin
            lat = 1;
        end else if (!st) begin
            if (sz == 0) begin
                v = int'(mm[i]);
                if (!f3[2] && v >= 128) v -= 256;
            end else if (sz == 1) begin
                v = int'(mm[i]) + 256 * int'(mm[i + 12'd1]);
                if (!f3[2] && v >= 32768) v -= 65536;
            end else begin
                v = int'({mm[i + 12'd3], mm[i + 12'd2], mm[i + 12'd1], mm[i]});
            end
            rd = 32'(v);
        end else begin
            if (sz == 0) begin
                mm[i] = wd[7:0];
                nb = 1;
            end else if (sz == 1) begin
                mm[i] = wd[7:0];
                mm[i + 12'd1] = wd[15:8];
                nb = 2;
                lat = 3;
            end else begin
                for (int k = 0; k < 4; k++) mm[i + 12'(k)] = wd[8*k +: 8];
                nw = 1;
            end
        end
    endfunction

    // Issue one request and collect response timing, data and RAM writes.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic flt, output logic [1:0] cs, output int nw, output int nb);
        int guard, w0, b0;
        guard = 0;
        lat = -1; rd = 32'd0; flt = 1'b0; cs = 2'b00;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            obs_addr[c] = 32'd0; obs_wdata[c] = 32'd0; obs_f3[c] = 3'd0;
            obs_re[c] = 1'b0; obs_bwe[c] = 1'b0; obs_wwe[c] = 1'b0;
        end
        w0 = nw_cnt;
        b0 = nb_cnt;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 3) begin
                obs_addr[c] = mem_address; obs_wdata[c] = mem_write_data; obs_f3[c] = mem_funct3;
                obs_re[c] = mem_re; obs_bwe[c] = mem_b_we; obs_wwe[c] = mem_w_we;
            end
            chk("busy_ready", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; flt = rsp_fault; cs = rsp_cause;
                chk("rsp_mem_idle", {29'd0, mem_re, mem_w_we, mem_b_we}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) begin
            @(negedge clk);
            chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        end
        nw = nw_cnt - w0;
        nb = nb_cnt - b0;
    endtask

    task automatic run_chk(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic eflt, flt;
        logic [1:0] ecs, cs;
        logic [31:0] erd;
        int elat, enw, enb, nw, nb;
        model_exec(st, f3, a, wd, eflt, ecs, erd, elat, enw, enb);
        do_req(st, f3, a, wd, lat, rd, flt, cs, nw, nb);
        chk("latency", 32'(lat), 32'(elat));
        chk("rdata", rd, erd);
        chk("fault", 32'(flt), 32'(eflt));
        chk("cause", 32'(cs), 32'(ecs));
        chk("word_writes", 32'(nw), 32'(enw));
        chk("byte_writes", 32'(nb), 32'(enb));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        for (int k = 0; k < 4096; k++) mm[k] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", 32'(req_ready), 32'd0);
        chk("rst_strobes", {29'd0, mem_re, mem_w_we, mem_b_we}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_rdata", rsp_rdata, 32'd0);
        chk("post_rst_fault", {29'd0, rsp_fault, rsp_cause}, 32'd0);
        chk("post_rst_addr", mem_address, 32'd0);
        @(negedge clk);

        // Byte and halfword loads from word 0x80FF1234 at 0x100.
        run_chk(1'b1, 3'b010, 32'h100, 32'h80FF1234, rd, lat);
        run_chk(1'b0, 3'b000, 32'h103, 32'h0, rd, lat);
        chk("lb_re", 32'(obs_re[1]), 32'd1);
        chk("lb_f3", 32'(obs_f3[1]), 32'd4);
        chk("lb_addr", obs_addr[1], 32'h103);
        chk("lb_val", rd, 32'hFFFFFF80);
        chk("lb_lat", 32'(lat), 32'd2);
        run_chk(1'b0, 3'b100, 32'h103, 32'h0, rd, lat);
        chk("lbu_val", rd, 32'h00000080);
        run_chk(1'b0, 3'b001, 32'h102, 32'h0, rd, lat);
        chk("lh_addr", obs_addr[1], 32'h100);
        chk("lh_f3", 32'(obs_f3[1]), 32'd2);
        chk("lh_val", rd, 32'hFFFF80FF);
        run_chk(1'b0, 3'b101, 32'h100, 32'h0, rd, lat);
        chk("lhu_val", rd, 32'h00001234);

        // SH as two byte writes, then read back.
        run_chk(1'b1, 3'b001, 32'h202, 32'hAAAABEEF, rd, lat);
        chk("sh_b1_we", 32'(obs_bwe[1]), 32'd1);
        chk("sh_b1_addr", obs_addr[1], 32'h202);
        chk("sh_b1_data", obs_wdata[1], 32'hEFEFEFEF);
        chk("sh_b2_we", 32'(obs_bwe[2]), 32'd1);
        chk("sh_b2_addr", obs_addr[2], 32'h203);
        chk("sh_b2_data", obs_wdata[2], 32'hBEBEBEBE);
        chk("sh_store_f3", 32'(obs_f3[1]), 32'd0);
        chk("sh_lat", 32'(lat), 32'd3);
        run_chk(1'b0, 3'b010, 32'h200, 32'h0, rd, lat);
        chk("lw_upper_half", {16'd0, rd[31:16]}, 32'h0000BEEF);

        // Faults.
        run_chk(1'b1, 3'b001, 32'h201, 32'hAAAABEEF, rd, lat);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_strobe", {29'd0, obs_re[1], obs_wwe[1], obs_bwe[1]}, 32'd0);
        run_chk(1'b0, 3'b011, 32'h100, 32'h0, rd, lat);
        run_chk(1'b1, 3'b100, 32'h100, 32'h0, rd, lat);
        run_chk(1'b0, 3'b010, 32'h102, 32'h0, rd, lat);

        // Reset while the second SH byte is being driven.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h400; req_wdata = 32'h0000CD78;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsh_b1_we", 32'(mem_b_we), 32'd1);
        chk("rsh_b1_addr", mem_address, 32'h400);
        @(negedge clk);
        chk("rsh_b2_addr", mem_address, 32'h401);
        rst = 1'b1;
        #1;
        chk("rsh_gate0", 32'(mem_b_we), 32'd0);
        @(negedge clk);
        chk("rsh_gate1", 32'(mem_b_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rsh_ready", 32'(req_ready), 32'd1);
        chk("rsh_valid", 32'(rsp_valid), 32'd0);
        chk("rsh_mem", {mem_address[28:0], mem_re, mem_w_we, mem_b_we}, 32'd0);
        chk("rsh_byte0", {24'd0, ram[12'h400]}, 32'h78);
        chk("rsh_byte1", {24'd0, ram[12'h401]}, 32'h00);
        mm[12'h400] = 8'h78;
        @(negedge clk);
        run_chk(1'b0, 3'b101, 32'h400, 32'h0, rd, lat);

        // Back-to-back with req_valid held high.
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h300; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_is_store = 1'b0; req_wdata = 32'h0;
        chk("b2b_busy1", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_sw_rsp", 32'(rsp_valid), 32'd1);
        chk("b2b_busy2", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_back", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_lw_wait", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("b2b_lw_rsp", 32'(rsp_valid), 32'd1);
        chk("b2b_lw_data", rsp_rdata, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) mm[12'h300 + 12'(k)] = 8'(32'hDEADBEEF >> (8 * k));
        @(negedge clk);

        // Randomized mix over a small window so misalignment and aliasing occur.
        for (int n = 0; n < 250; n++) begin
            bit st;
            logic [2:0] f3;
            logic [31:0] a;
            st = ($urandom_range(0, 1) == 1);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3[2] = st ? 1'b0 : f3[2];
            a  = 32'h800 + 32'($urandom_range(0, 63));
            run_chk(st, f3, a, $urandom, rd, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
